// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//   Turns the rising edge of a synchronous trigger into a fixed-width output
//   pulse followed by a mandatory low gap. Rising edges that arrive while the
//   block is busy are rejected, flagged for one cycle on `dropped`, and
//   counted in a saturating 8-bit `drop_count`.
//
//   Optional feature macro: PULSE_RETRIGGER_EN
//     defined   -> a rising edge during HIGH reloads the length counter and
//                  extends the pulse (not counted as dropped); a rising edge
//                  during GAP is still dropped.
//     undefined -> every rising edge outside IDLE is dropped (default build).
// ---------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 50,
  parameter int GAP_LEN   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  output logic       pulse_out,
  output logic       busy,
  output logic       dropped,
  output logic [7:0] drop_count
);

  // State encoding; 2'b11 is unused and recovers to IDLE.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HIGH = 2'b01;
  localparam logic [1:0] S_GAP  = 2'b10;

  // Counter reload values: the counter runs from LEN-1 down to 0.
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam bit               GAP_EN       = (GAP_LEN != 0);

  // Saturating increment for the rejected-edge counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_prev_q;
  logic             dropped_q, dropped_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic             rise_s;
  logic             retrig_s;
  logic             reject_s;

  // Edge detect against the previous trigger sample (reset value 1 so a
  // trigger held high through reset release does not fire).
  assign rise_s = trigger & ~trig_prev_q;

`ifdef PULSE_RETRIGGER_EN
  assign retrig_s = rise_s & (state_q == S_HIGH);
`else
  assign retrig_s = 1'b0;
`endif

  // A rise is accepted only in IDLE; in HIGH it may instead retrigger.
  assign reject_s = rise_s & (state_q != S_IDLE) & ~retrig_s;

  // State, counter, edge-detect and drop bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      trig_prev_q  <= 1'b1;
      dropped_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trig_prev_q  <= trigger;
      dropped_q    <= dropped_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Next-state and counter logic for the IDLE -> HIGH -> GAP -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d = S_HIGH;
          cnt_d   = PULSE_RELOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q;
        end
      end
      S_HIGH: begin
        if (retrig_s) begin
          state_d = S_HIGH;
          cnt_d   = PULSE_RELOAD;
        end else if (cnt_q != CNT_ZERO) begin
          state_d = S_HIGH;
          cnt_d   = cnt_q - CNT_ONE;
        end else if (GAP_EN) begin
          state_d = S_GAP;
          cnt_d   = GAP_RELOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      S_GAP: begin
        if (cnt_q != CNT_ZERO) begin
          state_d = S_GAP;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the one-cycle drop flag and the saturating drop counter.
  always_comb begin
    dropped_d    = 1'b0;
    drop_count_d = drop_count_q;
    if (reject_s) begin
      dropped_d    = 1'b1;
      drop_count_d = sat_inc(drop_count_q);
    end else begin
      dropped_d    = 1'b0;
      drop_count_d = drop_count_q;
    end
  end

  // Output decode taken only from registers, never from trigger.
  always_comb begin
    pulse_out  = (state_q == S_HIGH);
    busy       = (state_q != S_IDLE);
    dropped    = dropped_q;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretcher
//   Scoreboard bench: each applied cycle runs a timeline model (pulse end /
//   busy end edge numbers, drop tally) and queues the expected outputs for
//   the following clock edge; an independent monitor pops and compares
//   after every rising edge. Honours PULSE_RETRIGGER_EN like the design.
// ---------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int PL = 4;
  localparam int GL = 2;

`ifdef PULSE_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       trigger = 1'b0;
  logic       pulse_out;
  logic       busy;
  logic       dropped;
  logic [7:0] drop_count;

  pulse_stretcher #(
    .CNT_W    (8),
    .PULSE_LEN(PL),
    .GAP_LEN  (GL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .pulse_out (pulse_out),
    .busy      (busy),
    .dropped   (dropped),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         edge_no;
    logic       pulse;
    logic       busy;
    logic       dropped;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Timeline model: after clock edge E, pulse is high iff E < high_end and
  // busy iff E < idle_end.
  int edge_n   = 0;
  int high_end = 0;
  int idle_end = 0;
  bit prev_t   = 1'b1;
  int m_drops  = 0;

  task automatic model_step(input bit t, input bit r);
    exp_t e;
    bit   rise;
    bit   was_busy;
    bit   was_high;
    bit   drop;
    edge_n = edge_n + 1;
    drop   = 1'b0;
    if (!r) begin
      high_end = edge_n;
      idle_end = edge_n;
      prev_t   = 1'b1;
      m_drops  = 0;
    end else begin
      rise     = t && !prev_t;
      prev_t   = t;
      was_busy = (edge_n - 1) < idle_end;
      was_high = (edge_n - 1) < high_end;
      if (rise) begin
        if (!was_busy) begin
          high_end = edge_n + PL;
          idle_end = edge_n + PL + GL;
        end else if (RETRIG && was_high) begin
          high_end = edge_n + PL;
          idle_end = edge_n + PL + GL;
        end else begin
          drop    = 1'b1;
          m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
        end
      end
    end
    e.edge_no = edge_n;
    e.pulse   = edge_n < high_end;
    e.busy    = edge_n < idle_end;
    e.dropped = drop;
    e.cnt     = 8'(m_drops);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its prediction.
  task automatic cyc(input bit t, input bit r);
    @(negedge clk);
    trigger = t;
    reset   = r;
    model_step(t, r);
    if (!r) begin
      #1;
      n_vec = n_vec + 1;
      if (pulse_out !== 1'b0 || busy !== 1'b0 || dropped !== 1'b0 || drop_count !== 8'd0) begin
        n_err = n_err + 1;
        $display("FAIL async_reset t=%0t: got pulse=%b busy=%b dropped=%b count=%0d expected all 0",
                 $time, pulse_out, busy, dropped, drop_count);
      end
    end
  endtask

  task automatic seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      cyc(s.substr(i, i) == "1", 1'b1);
    end
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec = n_vec + 1;
        if (pulse_out !== e.pulse || busy !== e.busy || dropped !== e.dropped || drop_count !== e.cnt) begin
          n_err = n_err + 1;
          $display("FAIL outputs edge %0d: got pulse=%b busy=%b dropped=%b count=%0d expected pulse=%b busy=%b dropped=%b count=%0d",
                   e.edge_no, pulse_out, busy, dropped, drop_count, e.pulse, e.busy, e.dropped, e.cnt);
        end
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, reset abort, saturation.
  initial begin
    bit r_t;
    int wait_cyc;

    // Reset with trigger low, then idle.
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    seq("0000");

    // Single pulse.
    seq("1000000000");
    // Second rise two cycles into HIGH.
    seq("1010000000");
    // Rise in last GAP cycle dropped, following rise in IDLE accepted.
    seq("1000001010000000");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r_t = 1'($urandom_range(0, 1));
      cyc(r_t, 1'b1);
    end
    seq("00000000");

    // Reset during HIGH with trigger held high through release.
    seq("1111");
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    seq("111000101000000000");

    // Saturate the drop counter with a toggling trigger.
    for (int i = 0; i < 1200; i++) begin
      cyc(i[0] == 1'b0, 1'b1);
    end
    seq("0000000000");

    // Let the monitor drain the scoreboard, bounded.
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 5) begin
      @(posedge clk);
      #2;
      wait_cyc = wait_cyc + 1;
    end
    if (exp_q.size() > 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
